// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-requester arbiter and sequencer for a single SRAM port wrapper.
// Latency: request sampled in IDLE -> ack WAIT_CYCLES+2 cycles later; one transaction per WAIT_CYCLES+3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; requests are only looked at in IDLE.
//
// Ports: clk/rst (async active-high), a_*/b_* requester interfaces (req/we/addr/wdata in,
// ack/rdata out), sram_* wrapper interface (Address/Input/write/read out, Output in), busy.
// Optional build macro SRAM_ARB_RR_EN: round-robin on simultaneous requests
// (default: requester A has fixed priority).
module sram_arb_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [19:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [19:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [19:0] sram_Address,
  output logic [15:0] sram_Input,
  input  logic [15:0] sram_Output,
  output logic        sram_write,
  output logic        sram_read,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_b_q, gnt_b_d;   // 1: transaction in flight belongs to B
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        sram_write_q, sram_write_d;
  logic        sram_read_q, sram_read_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        busy_q, busy_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        pick_b;

`ifdef SRAM_ARB_RR_EN
  logic        last_b_q, last_b_d;  // 1: last grant went to B

  // On a tie, the requester that was not granted last wins.
  assign pick_b = b_req && (!a_req || !last_b_q);
`else
  assign pick_b = b_req && !a_req;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_b_d      = gnt_b_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sram_write_d = sram_write_q;
    sram_read_d  = sram_read_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_b_d     = last_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d = pick_b;
          we_d    = pick_b ? b_we    : a_we;
          addr_d  = pick_b ? b_addr  : a_addr;
          wdata_d = pick_b ? b_wdata : a_wdata;
          state_d = SETUP;
`ifdef SRAM_ARB_RR_EN
          last_b_d = pick_b;
`endif
        end
      end
      SETUP: begin
        state_d      = ACCESS;
        cnt_d        = CNT_LOAD;
        sram_write_d = we_q;
        sram_read_d  = !we_q;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d      = DONE;
          sram_write_d = 1'b0;
          sram_read_d  = 1'b0;
          // Capture on the final strobe cycle so rdata is valid alongside ack.
          if (!we_q) begin
            if (gnt_b_q) b_rdata_d = sram_Output;
            else         a_rdata_d = sram_Output;
          end
          a_ack_d = !gnt_b_q;
          b_ack_d = gnt_b_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      gnt_b_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 20'd0;
      wdata_q      <= 16'd0;
      sram_write_q <= 1'b0;
      sram_read_q  <= 1'b0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      a_rdata_q    <= 16'd0;
      b_rdata_q    <= 16'd0;
`ifdef SRAM_ARB_RR_EN
      last_b_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_b_q      <= gnt_b_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sram_write_q <= sram_write_d;
      sram_read_q  <= sram_read_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      busy_q       <= busy_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_b_q     <= last_b_d;
`endif
    end
  end

  assign sram_Address = addr_q;
  assign sram_Input   = wdata_q;
  assign sram_write   = sram_write_q;
  assign sram_read    = sram_read_q;
  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign busy         = busy_q;

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, number of cycles the read/write strobe is held asserted (legal 1..15).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_req / b_req  input  1  requester A/B transaction request; held until matching ack.
REQ-005 a_we / b_we  input  1  1 = write, 0 = read; valid while req high.
REQ-006 a_addr / b_addr  input  20  word address.
REQ-007 a_wdata / b_wdata  input  16  write data.
REQ-008 a_ack / b_ack  output  1  one-cycle completion pulse.
REQ-009 a_rdata / b_rdata  output  16  read data, registered, valid from ack cycle until that requester's next read completes.
REQ-010 sram_Address  output  20  address to the SRAM port wrapper.
REQ-011 sram_Input  output  16  write data to the wrapper.
REQ-012 sram_Output  input  16  read data from the wrapper.
REQ-013 sram_write / sram_read  output  1  wrapper strobes, active-high.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, ACCESS and DONE, and all outputs SHALL be registered.
REQ-016 IDLE: when any req is high, the FSM SHALL grant one requester, latch its we/addr/wdata into sram_Address/sram_Input, and go to SETUP; requests SHALL be sampled only in IDLE.
REQ-017 SETUP (1 cycle): address and data stable, both strobes 0; next state ACCESS, counter loaded with WAIT_CYCLES-1.
REQ-018 ACCESS: exactly one of sram_write or sram_read SHALL be 1 per latched we, for exactly WAIT_CYCLES cycles; the counter decrements and exit occurs at 0.
REQ-019 On the last ACCESS cycle of a read, sram_Output SHALL be captured into the granted requester's rdata.
REQ-020 DONE (1 cycle): both strobes 0 and the granted ack = 1; next state IDLE.
REQ-021 sram_Address and sram_Input SHALL remain constant from SETUP through DONE.
REQ-022 sram_read and sram_write SHALL never be 1 simultaneously, and neither SHALL be 1 outside ACCESS.
REQ-023 Latency: a req sampled in IDLE at edge N SHALL produce ack high during cycle N+WAIT_CYCLES+2; throughput SHALL be one transaction per WAIT_CYCLES+3 cycles.
REQ-024 A requester SHALL drop req in the cycle after ack; a req still high in IDLE SHALL start a new transaction.
REQ-025 A req dropped before ack SHALL NOT abort the in-flight transaction.
REQ-026 a_ack and b_ack SHALL never be 1 in the same cycle.
REQ-027 The non-granted requester's rdata SHALL be unaffected by a transaction.

Reset
REQ-028 While rst = 1, the block SHALL force the state to IDLE, all strobes, acks and busy to 0, sram_Address, sram_Input and both rdata to 0, the counter to 0, and last_grant to B, independent of clk.
REQ-029 Reset mid-transaction SHALL deassert the strobes immediately, issue no ack, and discard the transaction.

Configuration
REQ-030 Macro SRAM_ARB_RR_EN defined: on simultaneous requests in IDLE, the requester not granted last SHALL win, and last_grant SHALL update on every grant.
REQ-031 Macro SRAM_ARB_RR_EN undefined: A SHALL always win simultaneous requests (fixed priority), and the last_grant logic SHALL be absent.
REQ-032 Single-requester behaviour SHALL be identical in both builds.

Verification (WAIT_CYCLES = 2)
REQ-033 After reset, a_req=1, a_we=1, a_addr=20'h00010, a_wdata=16'hBEEF -> SETUP, then sram_write=1 for 2 cycles with sram_Address=20'h00010 and sram_Input=16'hBEEF, then a_ack pulse 4 cycles after acceptance.
REQ-034 b_req read at 20'h00010 with the SRAM model returning 16'hBEEF -> sram_read=1 for 2 cycles, b_rdata=16'hBEEF at b_ack, a_rdata unchanged.
REQ-035 a_req and b_req both high for 4 transactions with RR_EN -> grant order A,B,A,B; without RR_EN -> A is granted for as long as a_req stays high.
REQ-036 Assert rst during the second ACCESS cycle of a write -> sram_write=0 immediately, no ack, busy=0, and the next request completes normally.
REQ-037 Run 1000 random transactions with WAIT_CYCLES=1 and 15 -> scoreboard read-back matches, the no-dual-strobe and no-dual-ack assertions never fire, and each latency equals WAIT_CYCLES+2.
